lii_tx_arbiter: RTL and testbench

//  Frame-granular round-robin arbiter sharing one LII transmit channel among INPUTS LII sources.

---
 rtl/lii_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_lii_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one LII transmit channel among INPUTS sources.
// The owner's words reach TX combinationally; TX_RDY is routed back to the owner only.
module lii_tx_arbiter #(
   parameter int INPUTS     = 2,
   parameter int DATA_WIDTH = 64,
   parameter int META_WIDTH = 1,
   localparam int BV        = $clog2(DATA_WIDTH/8) + 1
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [INPUTS*DATA_WIDTH-1:0] RX_DATA,
   input  logic [INPUTS*BV-1:0]         RX_BYTES_VLD,
   input  logic [INPUTS*BV-1:0]         RX_EDB,
   input  logic [INPUTS-1:0]            RX_SOF,
   input  logic [INPUTS-1:0]            RX_EOF,
   input  logic [INPUTS-1:0]            RX_EEOF,
   input  logic [INPUTS*META_WIDTH-1:0] RX_META,
   input  logic [INPUTS-1:0]            RX_CRCERR,
   output logic [INPUTS-1:0]            RX_RDY,
   output logic [DATA_WIDTH-1:0]        TX_DATA,
   output logic [BV-1:0]                TX_BYTES_VLD,
   output logic [BV-1:0]                TX_EDB,
   output logic                         TX_SOF,
   output logic                         TX_EOF,
   output logic                         TX_EEOF,
   output logic [META_WIDTH-1:0]        TX_META,
   output logic                         TX_CRCERR,
   input  logic                         TX_RDY,
   input  logic                         TX_LINK_STATUS
);

   localparam int OW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   ptr_q, ptr_d;
   logic [INPUTS-1:0] others_req;

   function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
      if (int'(i) == INPUTS - 1) return '0;
      return i + 1'b1;
   endfunction

   // First asserted request at or after start, searching cyclically.
   function automatic logic [OW-1:0] rr_pick(input logic [INPUTS-1:0] req,
                                             input logic [OW-1:0]     start);
      logic [OW-1:0] idx;
      logic [OW-1:0] pick;
      logic          found;
      idx   = start;
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < INPUTS; k++) begin
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = next_idx(idx);
      end
      return pick;
   endfunction

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      others_req = RX_SOF & ~(INPUTS'(1) << owner_q);
      case (state_q)
         IDLE: begin
            if (TX_LINK_STATUS && |RX_SOF) begin
               owner_d = rr_pick(RX_SOF, ptr_q);
               state_d = BUSY;
            end
         end
         BUSY: begin
            // The old owner is excluded here so it can only come back through IDLE.
            if (RX_EOF[owner_q] && TX_RDY) begin
               ptr_d = next_idx(owner_q);
               if (TX_LINK_STATUS && |others_req) owner_d = rr_pick(others_req, next_idx(owner_q));
               else                               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      RX_RDY       = '0;
      TX_DATA      = '0;
      TX_BYTES_VLD = '0;
      TX_EDB       = '0;
      TX_SOF       = 1'b0;
      TX_EOF       = 1'b0;
      TX_EEOF      = 1'b0;
      TX_META      = '0;
      TX_CRCERR    = 1'b0;
      if (state_q == BUSY) begin
         RX_RDY[owner_q] = TX_RDY;
         TX_DATA         = RX_DATA[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
         TX_BYTES_VLD    = RX_BYTES_VLD[int'(owner_q)*BV +: BV];
         TX_EDB          = RX_EDB[int'(owner_q)*BV +: BV];
         TX_SOF          = RX_SOF[owner_q];
         TX_EOF          = RX_EOF[owner_q];
         TX_EEOF         = RX_EEOF[owner_q];
         TX_META         = RX_META[int'(owner_q)*META_WIDTH +: META_WIDTH];
         TX_CRCERR       = RX_CRCERR[owner_q];
      end
   end

endmodule

// File: tb/tb_lii_tx_arbiter.sv
// Directed bench for lii_tx_arbiter: two 64-bit sources driven as a linear sequence of steps.
module tb_lii_tx_arbiter;

   localparam int N  = 2;
   localparam int DW = 64;
   localparam int MW = 1;
   localparam int BV = 4;

   logic            CLK = 1'b0;
   logic            RESET;
   logic [N*DW-1:0] RX_DATA;
   logic [N*BV-1:0] RX_BYTES_VLD;
   logic [N*BV-1:0] RX_EDB;
   logic [N-1:0]    RX_SOF, RX_EOF, RX_EEOF, RX_CRCERR;
   logic [N*MW-1:0] RX_META;
   logic [N-1:0]    RX_RDY;
   logic [DW-1:0]   TX_DATA;
   logic [BV-1:0]   TX_BYTES_VLD, TX_EDB;
   logic            TX_SOF, TX_EOF, TX_EEOF, TX_CRCERR;
   logic [MW-1:0]   TX_META;
   logic            TX_RDY, TX_LINK_STATUS;

   int checks = 0;
   int errors = 0;

   lii_tx_arbiter #(.INPUTS(N), .DATA_WIDTH(DW), .META_WIDTH(MW)) dut (
      .CLK(CLK), .RESET(RESET),
      .RX_DATA(RX_DATA), .RX_BYTES_VLD(RX_BYTES_VLD), .RX_EDB(RX_EDB),
      .RX_SOF(RX_SOF), .RX_EOF(RX_EOF), .RX_EEOF(RX_EEOF), .RX_META(RX_META),
      .RX_CRCERR(RX_CRCERR), .RX_RDY(RX_RDY),
      .TX_DATA(TX_DATA), .TX_BYTES_VLD(TX_BYTES_VLD), .TX_EDB(TX_EDB),
      .TX_SOF(TX_SOF), .TX_EOF(TX_EOF), .TX_EEOF(TX_EEOF), .TX_META(TX_META),
      .TX_CRCERR(TX_CRCERR), .TX_RDY(TX_RDY), .TX_LINK_STATUS(TX_LINK_STATUS)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input int i, input logic sof, input logic eof,
                        input logic [63:0] data, input logic [3:0] bv);
      RX_DATA[i*DW +: DW]      = data;
      RX_BYTES_VLD[i*BV +: BV] = bv;
      RX_EDB[i*BV +: BV]       = '0;
      RX_SOF[i]                = sof;
      RX_EOF[i]                = eof;
      RX_EEOF[i]               = 1'b0;
      RX_META[i*MW +: MW]      = data[0];
      RX_CRCERR[i]             = 1'b0;
   endtask

   task automatic do_reset;
      drive(0, 1'b0, 1'b0, 64'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 64'h0, 4'h0);
      TX_RDY = 1'b1;
      RESET  = 1'b0;
      tick;
      RESET  = 1'b1;
   endtask

   int          w[2];
   int          f[2];
   int          eo, ew, ef;
   logic [1:0]  rdy_s;

   initial begin
      // Reset held with both sources requesting
      RESET          = 1'b0;
      TX_RDY         = 1'b1;
      TX_LINK_STATUS = 1'b1;
      drive(0, 1'b1, 1'b1, 64'hAAAA_0000_0000_0001, 4'h8);
      drive(1, 1'b1, 1'b1, 64'hBBBB_0000_0000_0001, 4'h8);
      tick;
      for (int c = 0; c < 3; c++) begin
         chk("rst_rdy", RX_RDY, 64'h0);
         chk("rst_sof", TX_SOF, 64'h0);
         chk("rst_data", TX_DATA, 64'h0);
         tick;
      end
      drive(0, 1'b0, 1'b0, 64'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 64'h0, 4'h0);
      RESET = 1'b1;
      #1 chk("post_rst_rdy", RX_RDY, 64'h0);
      tick;

      // Single source, 4-word frame
      drive(0, 1'b1, 1'b0, 64'hD0, 4'h0);
      #1 chk("single_idle_rdy", RX_RDY, 64'h0);
      chk("single_idle_sof", TX_SOF, 64'h0);
      tick;
      drive(0, 1'b1, 1'b0, 64'hD0, 4'h0);
      #1 chk("single_w0_data", TX_DATA, 64'hD0);
      chk("single_w0_sof", TX_SOF, 64'h1);
      chk("single_w0_rdy", RX_RDY, 64'h1);
      tick;
      drive(0, 1'b0, 1'b0, 64'hD1, 4'h0);
      #1 chk("single_w1_data", TX_DATA, 64'hD1);
      chk("single_w1_rdy", RX_RDY, 64'h1);
      tick;
      drive(0, 1'b0, 1'b0, 64'hD2, 4'h0);
      #1 chk("single_w2_data", TX_DATA, 64'hD2);
      tick;
      drive(0, 1'b0, 1'b1, 64'hD3, 4'h5);
      #1 chk("single_w3_data", TX_DATA, 64'hD3);
      chk("single_w3_eof", TX_EOF, 64'h1);
      chk("single_w3_bv", TX_BYTES_VLD, 64'h5);
      chk("single_w3_rdy", RX_RDY, 64'h1);
      tick;
      drive(0, 1'b0, 1'b0, 64'h0, 4'h0);
      #1 chk("single_end_rdy", RX_RDY, 64'h0);
      chk("single_end_eof", TX_EOF, 64'h0);
      tick;

      // Fairness: both sources stream 3-word frames; grants 0,1,0,1 back-to-back
      do_reset;
      w[0] = 0; w[1] = 0; f[0] = 0; f[1] = 0;
      for (int c = 0; c < 13; c++) begin
         for (int i = 0; i < 2; i++)
            drive(i, w[i] == 0, w[i] == 2, 64'((i << 16) | (f[i] << 8) | w[i]), 4'h8);
         #1;
         if (c == 0) begin
            chk("fair_idle_rdy", RX_RDY, 64'h0);
         end else begin
            eo = ((c - 1) / 3) % 2;
            ew = (c - 1) % 3;
            ef = (c - 1) / 6;
            chk("fair_data", TX_DATA, 64'((eo << 16) | (ef << 8) | ew));
            chk("fair_rdy", RX_RDY, 64'(1 << eo));
         end
         rdy_s = RX_RDY;
         tick;
         for (int i = 0; i < 2; i++) begin
            if (rdy_s[i]) begin
               if (w[i] == 2) begin
                  w[i] = 0;
                  f[i]++;
               end else begin
                  w[i]++;
               end
            end
         end
      end

      // Backpressure on a 3-word frame from in0
      do_reset;
      drive(0, 1'b1, 1'b0, 64'hB0, 4'h0);
      #1 chk("bp_idle_rdy", RX_RDY, 64'h0);
      tick;
      TX_RDY = 1'b1;
      drive(0, 1'b1, 1'b0, 64'hB0, 4'h0);
      #1 chk("bp_w0_data", TX_DATA, 64'hB0);
      chk("bp_w0_rdy", RX_RDY, 64'h1);
      tick;
      TX_RDY = 1'b0;
      drive(0, 1'b0, 1'b0, 64'hB1, 4'h0);
      #1 chk("bp_w1_stall_data", TX_DATA, 64'hB1);
      chk("bp_w1_stall_rdy", RX_RDY, 64'h0);
      tick;
      TX_RDY = 1'b1;
      #1 chk("bp_w1_go_data", TX_DATA, 64'hB1);
      chk("bp_w1_go_rdy", RX_RDY, 64'h1);
      tick;
      TX_RDY = 1'b0;
      drive(0, 1'b0, 1'b1, 64'hB2, 4'h2);
      #1 chk("bp_w2_stall_data", TX_DATA, 64'hB2);
      chk("bp_w2_stall_eof", TX_EOF, 64'h1);
      chk("bp_w2_stall_rdy", RX_RDY, 64'h0);
      tick;
      TX_RDY = 1'b1;
      #1 chk("bp_w2_go_data", TX_DATA, 64'hB2);
      chk("bp_w2_go_rdy", RX_RDY, 64'h1);
      tick;
      drive(0, 1'b0, 1'b0, 64'h0, 4'h0);
      #1 chk("bp_end_rdy", RX_RDY, 64'h0);
      tick;

      // Single-word frame on in1 (pointer now at 1), in0 pending
      drive(1, 1'b1, 1'b1, 64'h1111_0000_0000_0001, 4'h3);
      drive(0, 1'b1, 1'b1, 64'h2222_0000_0000_0000, 4'h7);
      #1 chk("sw_idle_rdy", RX_RDY, 64'h0);
      tick;
      #1 chk("sw_in1_data", TX_DATA, 64'h1111_0000_0000_0001);
      chk("sw_in1_sof", TX_SOF, 64'h1);
      chk("sw_in1_eof", TX_EOF, 64'h1);
      chk("sw_in1_bv", TX_BYTES_VLD, 64'h3);
      chk("sw_in1_meta", TX_META, 64'h1);
      chk("sw_in1_rdy", RX_RDY, 64'h2);
      tick;
      drive(1, 1'b0, 1'b0, 64'h0, 4'h0);
      #1 chk("sw_in0_data", TX_DATA, 64'h2222_0000_0000_0000);
      chk("sw_in0_bv", TX_BYTES_VLD, 64'h7);
      chk("sw_in0_rdy", RX_RDY, 64'h1);
      tick;
      drive(0, 1'b0, 1'b0, 64'h0, 4'h0);
      #1 chk("sw_end_rdy", RX_RDY, 64'h0);
      tick;

      // Link drops mid-frame, then mid-frame reset
      drive(0, 1'b1, 1'b0, 64'hC0, 4'h0);
      #1 chk("lk_idle_rdy", RX_RDY, 64'h0);
      tick;
      TX_LINK_STATUS = 1'b0;
      #1 chk("lk_w0_data", TX_DATA, 64'hC0);
      chk("lk_w0_rdy", RX_RDY, 64'h1);
      tick;
      drive(0, 1'b0, 1'b1, 64'hC1, 4'h4);
      #1 chk("lk_w1_eof", TX_EOF, 64'h1);
      chk("lk_w1_rdy", RX_RDY, 64'h1);
      tick;
      drive(0, 1'b1, 1'b0, 64'hE0, 4'h0);
      for (int c = 0; c < 2; c++) begin
         #1 chk("lk_down_rdy", RX_RDY, 64'h0);
         chk("lk_down_sof", TX_SOF, 64'h0);
         tick;
      end
      TX_LINK_STATUS = 1'b1;
      #1 chk("lk_up_idle_rdy", RX_RDY, 64'h0);
      tick;
      #1 chk("lk_up_data", TX_DATA, 64'hE0);
      chk("lk_up_sof", TX_SOF, 64'h1);
      chk("lk_up_rdy", RX_RDY, 64'h1);
      tick;
      drive(0, 1'b0, 1'b1, 64'hE1, 4'h6);
      #1 chk("mr_pre_eof", TX_EOF, 64'h1);
      chk("mr_pre_rdy", RX_RDY, 64'h1);
      RESET = 1'b0;
      #1 chk("mr_sof", TX_SOF, 64'h0);
      chk("mr_eof", TX_EOF, 64'h0);
      chk("mr_data", TX_DATA, 64'h0);
      chk("mr_rdy", RX_RDY, 64'h0);
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
